reg_file_sb: RTL
================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning register width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning number of registers (power of two, >=2); ADDR_W = clog2(DEPTH).
REQ-003 The block SHALL have parameter ZERO_REG, default 1, meaning 1 = register 0 reads 0 and ignores writes/issues.
REQ-004 The block SHALL have parameter BYPASS, default 1, meaning 1 = same-cycle write data forwarded to matching read ports.
REQ-005 The block SHALL have port clk  input  1  single clock, rising edge.
REQ-006 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 The block SHALL have port rd_addr_1  input  ADDR_W  read port 1 address.
REQ-008 The block SHALL have port rd_addr_2  input  ADDR_W  read port 2 address.
REQ-009 The block SHALL have port rd_data_1  output  DATA_W  read port 1 data.
REQ-010 The block SHALL have port rd_data_2  output  DATA_W  read port 2 data.
REQ-011 The block SHALL have port rd_busy_1  output  1  register at rd_addr_1 has a pending write.
REQ-012 The block SHALL have port rd_busy_2  output  1  register at rd_addr_2 has a pending write.
REQ-013 The block SHALL have port wr_en  input  1  writeback strobe.
REQ-014 The block SHALL have port wr_addr  input  ADDR_W  writeback address.
REQ-015 The block SHALL have port wr_data  input  DATA_W  writeback data.
REQ-016 The block SHALL have port iss_en  input  1  issue strobe: marks iss_addr as pending.
REQ-017 The block SHALL have port iss_addr  input  ADDR_W  destination of issued instruction.
REQ-018 The block SHALL have port busy_cnt  output  ADDR_W+1  number of registers currently pending.

Function
REQ-019 Reads SHALL be combinational: rd_data_n = reg[rd_addr_n]; rd_busy_n = busy[rd_addr_n].
REQ-020 On rising clk with wr_en=1, reg[wr_addr] SHALL take wr_data and busy[wr_addr] SHALL clear.
REQ-021 On rising clk with iss_en=1, busy[iss_addr] SHALL set.
REQ-022 iss_en and wr_en to the same address in one cycle SHALL leave busy set (new producer wins); data is still written.
REQ-023 A write to a non-busy register SHALL be accepted; busy stays 0.
REQ-024 An issue to an already-busy register SHALL leave busy set; busy_cnt unchanged.
REQ-025 With BYPASS=1, wr_en=1 and wr_addr==rd_addr_n SHALL give rd_data_n=wr_data and rd_busy_n=0 in the same cycle, unless REQ-022 applies to that address (then rd_busy_n=1).
REQ-026 With BYPASS=0, read ports SHALL show pre-edge register and busy contents.
REQ-027 With ZERO_REG=1, address 0 SHALL read data 0 and busy 0; writes and issues to it SHALL be ignored and never bypassed.
REQ-028 busy_cnt SHALL be a registered count equal to popcount(busy), updated in the same edge as busy; it SHALL never exceed DEPTH (or DEPTH-1 with ZERO_REG=1).
REQ-029 Out-of-range addresses SHALL not arise since DEPTH is a power of two; no wrap logic is required.

Reset
REQ-030 rst=0 SHALL asynchronously clear all registers to 0, all busy bits to 0, busy_cnt to 0.
REQ-031 rst=0 mid-operation SHALL discard pending issues; after release the first rising edge SHALL behave per REQ-020..022.
REQ-032 During reset rd_data_n SHALL read 0 and rd_busy_n 0; bypass SHALL be suppressed.

Structure
REQ-033 Default DATA_W/DEPTH and a function for 1-bit count SHALL live in shared package cpu16_pkg.
REQ-034 The busy-bit array and busy_cnt logic SHALL be one sub-module, reg_scoreboard; storage and bypass stay in reg_file_sb.

Verification
REQ-035 Reset: drive rst=0 then 1, read all 16 addresses -> all data 0x0000, busy 0, busy_cnt 0.
REQ-036 Issue r5, next cycle write r5=0xBEEF -> rd_busy(r5)=1 and busy_cnt=1 after issue; data 0xBEEF, busy 0, busy_cnt 0 after write.
REQ-037 Bypass: wr_en, wr_addr=3, wr_data=0x1234, rd_addr_1=3 same cycle -> rd_data_1=0x1234 before edge; BYPASS=0 build -> old value.
REQ-038 Collision: r7 busy, same cycle iss_en r7 and wr_en r7=0x00AA -> r7=0x00AA, busy stays 1, busy_cnt unchanged.
REQ-039 Zero reg: write r0=0xFFFF and issue r0 -> rd_data=0x0000, busy 0, busy_cnt 0.
REQ-040 Reset mid-flight: issue r1,r2,r3, assert rst between edges -> busy_cnt 0 immediately, all registers 0.

Source files
------------

// File: rtl/cpu16_pkg.sv
// Shared definitions for the cpu16 datapath: default register-file geometry
// and a population-count helper used by the scoreboard.
package cpu16_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_DEPTH  = 16;

    // Widest busy vector the helper accepts; narrower vectors are zero-padded.
    localparam int MAX_REGS = 64;

    function automatic int unsigned count_ones(input logic [MAX_REGS-1:0] vec);
        int unsigned total;
        total = 0;
        for (int i = 0; i < MAX_REGS; i++) begin
            total += {31'b0, vec[i]};
        end
        return total;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one pending flag per register plus a registered count
// of how many flags are set.
module reg_scoreboard
    import cpu16_pkg::*;
#(
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = $clog2(DEPTH),
    localparam int CNT_W   = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic              iss_en_i,
    input  logic [ADDR_W-1:0] iss_addr_i,
    output logic [DEPTH-1:0]  busy_o,
    output logic [CNT_W-1:0]  busy_cnt_o
);

    logic [DEPTH-1:0]    busy_q, busy_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [MAX_REGS-1:0] paddedBusy;

    // Issue is applied after writeback so a new producer wins a same-cycle collision.
    always_comb begin
        busy_d = busy_q;
        if (wr_en_i) begin
            busy_d[wr_addr_i] = 1'b0;
        end
        if (iss_en_i) begin
            busy_d[iss_addr_i] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
        paddedBusy = '0;
        paddedBusy[DEPTH-1:0] = busy_d;
        cnt_d = CNT_W'(count_ones(paddedBusy));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o     = busy_q;
    assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Two-read, one-write register file with an issue/writeback scoreboard and
// optional same-cycle writeback forwarding.
module reg_file_sb
    import cpu16_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_1,
    input  logic [ADDR_W-1:0] rd_addr_2,
    output logic [DATA_W-1:0] rd_data_1,
    output logic [DATA_W-1:0] rd_data_2,
    output logic              rd_busy_1,
    output logic              rd_busy_2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic [ADDR_W:0]   busy_cnt
);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busyVec;
    logic              wrLive;
    logic [ADDR_W-1:0] rdAddr [2];
    logic [DATA_W-1:0] rdData [2];
    logic              rdBusy [2];

    reg_scoreboard #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .iss_en_i   (iss_en),
        .iss_addr_i (iss_addr),
        .busy_o     (busyVec),
        .busy_cnt_o (busy_cnt)
    );

    // A write is only real out of reset and when it does not target the hardwired zero register.
    assign wrLive = rst && wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wrLive) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    assign rdAddr[0] = rd_addr_1;
    assign rdAddr[1] = rd_addr_2;

    // Forwarded reads report busy only if the same address is being re-issued this cycle.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdData[p] = regs_q[rdAddr[p]];
            rdBusy[p] = busyVec[rdAddr[p]];
            if ((BYPASS != 0) && wrLive && (wr_addr == rdAddr[p])) begin
                rdData[p] = wr_data;
                rdBusy[p] = iss_en && (iss_addr == wr_addr);
            end
            if ((ZERO_REG != 0) && (rdAddr[p] == '0)) begin
                rdData[p] = '0;
                rdBusy[p] = 1'b0;
            end
        end
    end

    assign rd_data_1 = rdData[0];
    assign rd_data_2 = rdData[1];
    assign rd_busy_1 = rdBusy[0];
    assign rd_busy_2 = rdBusy[1];

endmodule
